rr_packet_router: RTL and testbench

- Parametrised, clocked successor of the team's fixed two-port combinational routing block.
- Accepts packets on NUM_IN valid/ready input channels. Each packet carries a destination index.
- Per-output round-robin arbitration picks one input; the packet is buffered in a per-output FIFO and presented on a valid/ready output channel.
- Packets with an out-of-range destination are consumed, dropped and counted.

---
 rtl/rr_packet_router.sv | 148 ++++++++++++++
 tb/tb_rr_packet_router.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_packet_router.sv
// Multi-input packet router. Each output has a round-robin arbiter that picks
// one requesting input per cycle and pushes the packet into a small FIFO.
// Packets addressed past the last output are accepted, dropped and counted.
module rr_packet_router #(
  parameter int unsigned NUM_IN     = 2,
  parameter int unsigned NUM_OUT    = 2,
  parameter int unsigned DATA_W     = 30,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8,
  localparam int unsigned DEST_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
  localparam int unsigned SRC_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IN-1:0]          in_valid,
  output logic [NUM_IN-1:0]          in_ready,
  input  logic [NUM_IN*DEST_W-1:0]   in_dest,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready,
  output logic [NUM_OUT*DATA_W-1:0]  out_data,
  output logic [NUM_OUT*SRC_W-1:0]   out_src,
  output logic [NUM_OUT-1:0]         fifo_full,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int unsigned ENT_W = SRC_W + DATA_W;
  // Wide enough for the current count plus one drop from every input
  localparam int unsigned SUM_W = CNT_W + SRC_W + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

  logic [DEST_W-1:0] w_dest [NUM_IN];
  logic [DATA_W-1:0] w_data [NUM_IN];
  logic [NUM_IN-1:0] w_bad;
  logic [NUM_OUT-1:0] w_found;
  logic [NUM_OUT-1:0] w_push;
  logic [NUM_OUT-1:0] w_pop;
  logic [NUM_OUT-1:0] w_full;
  logic [SRC_W-1:0] w_gnt [NUM_OUT];
  logic [SRC_W-1:0] w_rr_nxt [NUM_OUT];
  logic [ENT_W-1:0] w_wdata [NUM_OUT];
  logic [SUM_W-1:0] w_drop_sum;
  logic [CNT_W-1:0] w_drop_d;

  logic [ENT_W-1:0] r_mem [NUM_OUT][FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr [NUM_OUT];
  logic [PTR_W-1:0] r_rptr [NUM_OUT];
  logic [PTR_W:0]   r_cnt [NUM_OUT];
  logic [SRC_W-1:0] r_rr [NUM_OUT];
  logic [CNT_W-1:0] r_drop;

  // Unpack flat input buses and flag out-of-range destinations
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      w_dest[i] = in_dest[i*DEST_W +: DEST_W];
      w_data[i] = in_data[i*DATA_W +: DATA_W];
      w_bad[i]  = in_valid[i] && (32'(w_dest[i]) >= NUM_OUT);
    end
  end

  // Per-output round-robin scan starting at the stored pointer
  always_comb begin
    for (int d = 0; d < NUM_OUT; d++) begin
      w_found[d]  = 1'b0;
      w_gnt[d]    = '0;
      w_rr_nxt[d] = '0;
      w_wdata[d]  = '0;
      for (int k = 0; k < NUM_IN; k++) begin
        int idx;
        idx = int'(r_rr[d]) + k;
        if (idx >= int'(NUM_IN)) idx = idx - int'(NUM_IN);
        if (!w_found[d] && in_valid[idx] && (int'(w_dest[idx]) == d)) begin
          w_found[d]  = 1'b1;
          w_gnt[d]    = SRC_W'(idx);
          w_wdata[d]  = {SRC_W'(idx), w_data[idx]};
          w_rr_nxt[d] = (idx + 1 == int'(NUM_IN)) ? '0 : SRC_W'(idx + 1);
        end
      end
      // Full is the registered level, so a same-cycle pop never frees a slot
      w_push[d] = w_found[d] && !w_full[d];
      w_pop[d]  = out_valid[d] && out_ready[d];
    end
  end

  // Input handshake: drops are always accepted, otherwise only the pushed grant
  always_comb begin
    in_ready = w_bad;
    for (int d = 0; d < NUM_OUT; d++) begin
      if (w_push[d]) in_ready[w_gnt[d]] = 1'b1;
    end
  end

  // Saturating add of every drop seen this cycle
  always_comb begin
    w_drop_sum = SUM_W'(r_drop);
    for (int i = 0; i < NUM_IN; i++) begin
      w_drop_sum = w_drop_sum + SUM_W'(w_bad[i]);
    end
    w_drop_d = (w_drop_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
  end

  // FIFO status and head-of-queue outputs
  always_comb begin
    for (int d = 0; d < NUM_OUT; d++) begin
      w_full[d]    = (r_cnt[d] == FULL_LVL);
      fifo_full[d] = w_full[d];
      out_valid[d] = (r_cnt[d] != '0);
      {out_src[d*SRC_W +: SRC_W], out_data[d*DATA_W +: DATA_W]} = r_mem[d][r_rptr[d]];
    end
    drop_cnt = r_drop;
  end

  // FIFO storage, pointers, occupancy and arbiter pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < NUM_OUT; d++) begin
        r_wptr[d] <= '0;
        r_rptr[d] <= '0;
        r_cnt[d]  <= '0;
        r_rr[d]   <= '0;
        for (int e = 0; e < FIFO_DEPTH; e++) r_mem[d][e] <= '0;
      end
    end else begin
      for (int d = 0; d < NUM_OUT; d++) begin
        if (w_push[d]) begin
          r_mem[d][r_wptr[d]] <= w_wdata[d];
          r_wptr[d]           <= r_wptr[d] + PTR_W'(1);
          r_rr[d]             <= w_rr_nxt[d];
        end
        if (w_pop[d]) r_rptr[d] <= r_rptr[d] + PTR_W'(1);
        if (w_push[d] && !w_pop[d]) begin
          r_cnt[d] <= r_cnt[d] + (PTR_W+1)'(1);
        end else if (!w_push[d] && w_pop[d]) begin
          r_cnt[d] <= r_cnt[d] - (PTR_W+1)'(1);
        end
      end
    end
  end

  // Drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_drop <= '0;
    else     r_drop <= w_drop_d;
  end

endmodule

// File: tb/tb_rr_packet_router.sv
// Bench for rr_packet_router: a directed vector table, hand-written corner
// sequences (full FIFO, drops, async reset) and a randomized run against a
// queue-based reference model.
module tb_rr_packet_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: default 2x2 configuration
  logic        rst_a;
  logic [1:0]  a_in_valid, a_in_ready, a_in_dest;
  logic [59:0] a_in_data;
  logic [1:0]  a_out_valid, a_out_ready, a_out_src, a_fifo_full;
  logic [59:0] a_out_data;
  logic [7:0]  a_drop;

  rr_packet_router u_dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_dest   (a_in_dest),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_src   (a_out_src),
    .fifo_full (a_fifo_full),
    .drop_cnt  (a_drop)
  );

  // Instance B: 3 outputs so destination 3 is out of range, 2-bit drop counter
  logic        rst_b;
  logic [1:0]  b_in_valid, b_in_ready;
  logic [3:0]  b_in_dest;
  logic [59:0] b_in_data;
  logic [2:0]  b_out_valid, b_out_ready, b_out_src, b_fifo_full;
  logic [89:0] b_out_data;
  logic [1:0]  b_drop;

  rr_packet_router #(
    .NUM_IN     (2),
    .NUM_OUT    (3),
    .DATA_W     (30),
    .FIFO_DEPTH (4),
    .CNT_W      (2)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_dest   (b_in_dest),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_src   (b_out_src),
    .fifo_full (b_fifo_full),
    .drop_cnt  (b_drop)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  dst;
    logic [29:0] d0;
    logic [29:0] d1;
    logic [1:0]  ordy;
    logic [1:0]  rdy;
    logic [1:0]  ovld;
    logic [1:0]  src;
    logic [29:0] e0;
    logic [29:0] e1;
  } vec_t;

  function automatic vec_t mk(logic [1:0] vld, logic [1:0] dst, logic [29:0] d0,
                              logic [29:0] d1, logic [1:0] ordy, logic [1:0] rdy,
                              logic [1:0] ovld, logic [1:0] src, logic [29:0] e0,
                              logic [29:0] e1);
    vec_t v;
    v.vld = vld; v.dst = dst; v.d0 = d0; v.d1 = d1; v.ordy = ordy;
    v.rdy = rdy; v.ovld = ovld; v.src = src; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  vec_t tv [10];

  // Reference model state
  typedef logic [30:0] ent_t;
  ent_t       mq [2][$];
  int         mptr [2];
  int         gsrc [2];
  logic [1:0] gfound, erdy, acc, ev, ef;
  ent_t       h;

  initial begin
    // in_dest = {dest1, dest0}; src field bit d is out_src for output d
    tv[0] = mk(2'b01, 2'b01, 30'h155, 30'h0, 2'b00, 2'b01, 2'b00, 2'b00, 30'h0, 30'h0);
    tv[1] = mk(2'b00, 2'b00, 30'h0, 30'h0, 2'b10, 2'b00, 2'b10, 2'b00, 30'h0, 30'h155);
    tv[2] = mk(2'b11, 2'b00, 30'hA0, 30'hB0, 2'b01, 2'b01, 2'b00, 2'b00, 30'h0, 30'h0);
    tv[3] = mk(2'b11, 2'b00, 30'hA1, 30'hB0, 2'b01, 2'b10, 2'b01, 2'b00, 30'hA0, 30'h0);
    tv[4] = mk(2'b11, 2'b00, 30'hA1, 30'hB1, 2'b01, 2'b01, 2'b01, 2'b01, 30'hB0, 30'h0);
    tv[5] = mk(2'b11, 2'b00, 30'hA2, 30'hB1, 2'b01, 2'b10, 2'b01, 2'b00, 30'hA1, 30'h0);
    tv[6] = mk(2'b00, 2'b00, 30'h0, 30'h0, 2'b01, 2'b00, 2'b01, 2'b01, 30'hB1, 30'h0);
    tv[7] = mk(2'b11, 2'b10, 30'hC0, 30'hC1, 2'b00, 2'b11, 2'b00, 2'b00, 30'h0, 30'h0);
    tv[8] = mk(2'b00, 2'b00, 30'h0, 30'h0, 2'b11, 2'b00, 2'b11, 2'b10, 30'hC0, 30'hC1);
    tv[9] = mk(2'b00, 2'b00, 30'h0, 30'h0, 2'b00, 2'b00, 2'b00, 2'b00, 30'h0, 30'h0);

    rst_a = 1'b1; rst_b = 1'b1;
    a_in_valid = '0; a_in_dest = '0; a_in_data = '0; a_out_ready = '0;
    b_in_valid = '0; b_in_dest = '0; b_in_data = '0; b_out_ready = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", a_out_valid, 2'b00);
    chk("rst_fifo_full", a_fifo_full, 2'b00);
    chk("rst_out_data", a_out_data, 60'h0);
    chk("rst_out_src", a_out_src, 2'b00);
    chk("rst_drop_cnt", a_drop, 8'h0);
    chk("rst_in_ready", a_in_ready, 2'b00);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Directed vector table
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      a_in_valid  = tv[v].vld;
      a_in_dest   = tv[v].dst;
      a_in_data   = {tv[v].d1, tv[v].d0};
      a_out_ready = tv[v].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", v), a_in_ready, tv[v].rdy);
      chk($sformatf("vec%0d_out_valid", v), a_out_valid, tv[v].ovld);
      if (tv[v].ovld[0]) begin
        chk($sformatf("vec%0d_src0", v), a_out_src[0], tv[v].src[0]);
        chk($sformatf("vec%0d_data0", v), a_out_data[29:0], tv[v].e0);
      end
      if (tv[v].ovld[1]) begin
        chk($sformatf("vec%0d_src1", v), a_out_src[1], tv[v].src[1]);
        chk($sformatf("vec%0d_data1", v), a_out_data[59:30], tv[v].e1);
      end
    end

    // Full FIFO: five packets to output 0 with no drain
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_in_valid = 2'b01; a_in_dest = 2'b00; a_out_ready = 2'b00;
      a_in_data  = {30'h0, 30'h300 + 30'(k)};
      #1;
      chk($sformatf("full_in_ready%0d", k), a_in_ready, (k < 4) ? 2'b01 : 2'b00);
      chk($sformatf("full_flag%0d", k), a_fifo_full, (k == 4) ? 2'b01 : 2'b00);
    end
    @(negedge clk);
    a_out_ready = 2'b01;
    #1;
    chk("full_pop_blocks_push", a_in_ready, 2'b00);
    chk("full_head", a_out_data[29:0], 30'h300);
    @(negedge clk);
    a_out_ready = 2'b00;
    #1;
    chk("full_after_pop_flag", a_fifo_full, 2'b00);
    chk("full_after_pop_ready", a_in_ready, 2'b01);
    @(negedge clk);
    a_in_valid = 2'b00;
    #1;
    chk("full_refilled", a_fifo_full, 2'b01);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      a_out_ready = 2'b01;
      #1;
      chk($sformatf("drain_valid%0d", k), a_out_valid, 2'b01);
      chk($sformatf("drain_data%0d", k), a_out_data[29:0], 30'h300 + 30'(k));
      chk($sformatf("drain_src%0d", k), a_out_src[0], 1'b0);
    end
    @(negedge clk);
    a_out_ready = 2'b00;
    #1;
    chk("drain_empty", a_out_valid, 2'b00);

    // Drops on instance B: two per cycle, 2-bit counter saturates at 3
    @(negedge clk);
    b_in_valid = 2'b11; b_in_dest = 4'b1111;
    #1;
    chk("drop_ready0", b_in_ready, 2'b11);
    chk("drop_cnt0", b_drop, 2'd0);
    @(negedge clk);
    #1;
    chk("drop_ready1", b_in_ready, 2'b11);
    chk("drop_cnt1", b_drop, 2'd2);
    chk("drop_no_valid", b_out_valid, 3'b000);
    @(negedge clk);
    b_in_valid = 2'b00;
    #1;
    chk("drop_cnt_sat", b_drop, 2'd3);
    chk("drop_no_valid2", b_out_valid, 3'b000);

    // Async reset with three packets buffered in B
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b_in_valid = 2'b01; b_in_dest = 4'b0000; b_in_data = {30'h0, 30'h500 + 30'(k)};
      #1;
      chk($sformatf("pre_rst_ready%0d", k), b_in_ready, 2'b01);
    end
    @(negedge clk);
    b_in_valid = 2'b00;
    #1;
    chk("pre_rst_valid", b_out_valid, 3'b001);
    #1;
    rst_b = 1'b1;
    #1;
    chk("async_rst_valid", b_out_valid, 3'b000);
    chk("async_rst_drop", b_drop, 2'd0);
    chk("async_rst_full", b_fifo_full, 3'b000);
    @(negedge clk);
    rst_b = 1'b0;
    b_in_valid = 2'b10; b_in_dest = 4'b1000; b_in_data = {30'h1234, 30'h0};
    #1;
    chk("post_rst_ready", b_in_ready, 2'b10);
    chk("post_rst_empty", b_out_valid, 3'b000);
    @(negedge clk);
    b_in_valid = 2'b00;
    #1;
    chk("post_rst_valid", b_out_valid, 3'b100);
    chk("post_rst_data", b_out_data[89:60], 30'h1234);
    chk("post_rst_src", b_out_src[2], 1'b1);

    // Randomized run on A against the queue model
    @(negedge clk);
    rst_a = 1'b1; a_in_valid = '0; a_out_ready = '0;
    @(negedge clk);
    rst_a = 1'b0;
    mptr[0] = 0; mptr[1] = 0; acc = '0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!a_in_valid[i] || acc[i]) begin
          a_in_valid[i] = ($urandom_range(0, 99) < 60);
          a_in_dest[i]  = 1'($urandom_range(0, 1));
          a_in_data[i*30 +: 30] = 30'($urandom);
        end
      end
      a_out_ready = 2'($urandom);
      #1;
      erdy = '0; gfound = '0; ev = '0; ef = '0;
      for (int d = 0; d < 2; d++) begin
        ev[d] = (mq[d].size() > 0);
        ef[d] = (mq[d].size() == 4);
        if (mq[d].size() < 4) begin
          for (int k = 0; k < 2; k++) begin
            int i;
            i = (mptr[d] + k) % 2;
            if (!gfound[d] && a_in_valid[i] && (int'(a_in_dest[i]) == d)) begin
              gfound[d] = 1'b1; gsrc[d] = i; erdy[i] = 1'b1;
            end
          end
        end
      end
      chk("rnd_in_ready", a_in_ready, erdy);
      chk("rnd_out_valid", a_out_valid, ev);
      chk("rnd_fifo_full", a_fifo_full, ef);
      for (int d = 0; d < 2; d++) begin
        if (mq[d].size() > 0) begin
          h = mq[d][0];
          chk("rnd_head_src", a_out_src[d], h[30]);
          chk("rnd_head_data", a_out_data[d*30 +: 30], h[29:0]);
        end
      end
      acc = erdy & a_in_valid;
      for (int d = 0; d < 2; d++) begin
        if (a_out_ready[d] && mq[d].size() > 0) void'(mq[d].pop_front());
        if (gfound[d]) begin
          mq[d].push_back({1'(gsrc[d]), a_in_data[gsrc[d]*30 +: 30]});
          mptr[d] = (gsrc[d] + 1) % 2;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
